// File: rtl/pe_acc_if.sv
// Handshake bundle between the PE product stream, the accumulator and the
// result collector.
interface pe_acc_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
);
    logic              acc_start;
    logic [LEN_W-1:0]  acc_len;
    logic              c1_vld;
    logic [PROD_W-1:0] c1_data;
    logic              res_rdy;
    logic              res_vld;
    logic [ACC_W-1:0]  res_data;
    logic              res_sat;
    logic              acc_busy;
    logic              drop_err;

    modport master (
        output acc_start, acc_len, c1_vld, c1_data, res_rdy,
        input  res_vld, res_data, res_sat, acc_busy, drop_err
    );

    modport slave (
        input  acc_start, acc_len, c1_vld, c1_data, res_rdy,
        output res_vld, res_data, res_sat, acc_busy, drop_err
    );
endinterface

// File: rtl/pe_acc.sv
// Dot-product accumulator: sums K unsigned PE products with optional clamp to
// all-ones and presents the result over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for acc_start
// ACC   | collecting products until the remaining count reaches zero
// HOLD  | result valid, held until res_rdy
module pe_acc #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    pe_acc_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic              sat, sat_nxt;
    logic              drop, drop_nxt;
    logic              start_ok;
    logic [ACC_W:0]    sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            sat   <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            sat   <= sat_nxt;
            drop  <= drop_nxt;
        end
    end

    // One extra bit catches the carry out that triggers the clamp.
    assign sum = {1'b0, acc} + (ACC_W + 1)'(bus.c1_data);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        sat_nxt   = sat;
        drop_nxt  = drop;
        start_ok  = bus.acc_start &&
                    ((state == IDLE) || ((state == HOLD) && bus.res_rdy));

        if (start_ok) begin
            sat_nxt = 1'b0;
            if (bus.acc_len == '0) begin
                acc_nxt   = '0;
                rem_nxt   = '0;
                state_nxt = HOLD;
                if (bus.c1_vld) drop_nxt = 1'b1;
            end else if (bus.c1_vld) begin
                acc_nxt   = ACC_W'(bus.c1_data);
                rem_nxt   = bus.acc_len - LEN_W'(1);
                state_nxt = (bus.acc_len == LEN_W'(1)) ? HOLD : ACC;
            end else begin
                acc_nxt   = '0;
                rem_nxt   = bus.acc_len;
                state_nxt = ACC;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.c1_vld) drop_nxt = 1'b1;
                end
                ACC: begin
                    if (bus.c1_vld) begin
                        if (sum[ACC_W]) begin
                            acc_nxt = '1;
                            sat_nxt = 1'b1;
                        end else begin
                            acc_nxt = sum[ACC_W-1:0];
                        end
                        rem_nxt = rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_rdy) state_nxt = IDLE;
                    if (bus.c1_vld) drop_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.res_vld  = (state == HOLD);
    assign bus.res_data = (state == HOLD) ? acc : '0;
    assign bus.res_sat  = (state == HOLD) && sat;
    assign bus.acc_busy = (state != IDLE);
    assign bus.drop_err = drop;

endmodule

// File: tb/tb_pe_acc.sv
// Directed bench for pe_acc: a 32-bit instance for the main scenarios and a
// 17-bit instance for saturation.
module tb_pe_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pe_acc_if #(.PROD_W(16), .ACC_W(32), .LEN_W(8)) b1 ();
    pe_acc_if #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) b2 ();

    pe_acc #(.PROD_W(16), .ACC_W(32), .LEN_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pe_acc #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic st, input logic [7:0] len, input logic v,
                          input logic [15:0] d, input logic rdy);
        b1.acc_start = st;
        b1.acc_len   = len;
        b1.c1_vld    = v;
        b1.c1_data   = d;
        b1.res_rdy   = rdy;
    endtask

    task automatic drive2(input logic st, input logic [7:0] len, input logic v,
                          input logic [15:0] d, input logic rdy);
        b2.acc_start = st;
        b2.acc_len   = len;
        b2.c1_vld    = v;
        b2.c1_data   = d;
        b2.res_rdy   = rdy;
    endtask

    initial begin
        drive1(0, 0, 0, 0, 0);
        drive2(0, 0, 0, 0, 0);
        #12;
        check("rst_res_vld", 32'(b1.res_vld), 0);
        check("rst_res_data", b1.res_data, 0);
        check("rst_busy", 32'(b1.acc_busy), 0);
        check("rst_drop", 32'(b1.drop_err), 0);
        check("rst_res_sat", 32'(b1.res_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single run, len=4, first product on the start cycle
        drive1(1, 4, 1, 10, 1);
        tick();
        check("run_busy", 32'(b1.acc_busy), 1);
        drive1(0, 0, 1, 20, 1);
        tick();
        drive1(0, 0, 1, 30, 1);
        tick();
        check("run_no_early_vld", 32'(b1.res_vld), 0);
        drive1(0, 0, 1, 40, 1);
        tick();
        drive1(0, 0, 0, 0, 1);
        check("run_vld", 32'(b1.res_vld), 1);
        check("run_data", b1.res_data, 100);
        check("run_sat", 32'(b1.res_sat), 0);
        tick();
        check("run_idle_vld", 32'(b1.res_vld), 0);
        check("run_idle_busy", 32'(b1.acc_busy), 0);

        // gapped products with backpressure
        drive1(1, 3, 0, 0, 0);
        tick();
        drive1(0, 0, 1, 65025, 0); tick();
        drive1(0, 0, 0, 16'hdead, 0); tick();
        drive1(0, 0, 1, 65025, 0); tick();
        drive1(0, 0, 0, 16'hbeef, 0); tick();
        drive1(0, 0, 0, 0, 0); tick();
        drive1(0, 0, 1, 65025, 0); tick();
        drive1(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", 32'(b1.res_vld), 1);
            check("bp_data", b1.res_data, 195075);
            tick();
        end
        check("bp_still_busy", 32'(b1.acc_busy), 1);
        drive1(0, 0, 0, 0, 1);
        tick();
        check("bp_busy_fall", 32'(b1.acc_busy), 0);
        check("bp_drop", 32'(b1.drop_err), 0);

        // back-to-back: HOLD taken while a new start and its first product arrive
        drive1(1, 1, 1, 3, 0);
        tick();
        check("b2b_first_data", b1.res_data, 3);
        drive1(1, 2, 1, 7, 1);
        tick();
        check("b2b_taken_vld", 32'(b1.res_vld), 0);
        check("b2b_busy", 32'(b1.acc_busy), 1);
        drive1(0, 0, 1, 8, 0);
        tick();
        check("b2b_vld", 32'(b1.res_vld), 1);
        check("b2b_data", b1.res_data, 15);
        check("b2b_drop", 32'(b1.drop_err), 0);
        drive1(0, 0, 0, 0, 1);
        tick();

        // len=0
        drive1(1, 0, 0, 0, 0);
        tick();
        check("len0_vld", 32'(b1.res_vld), 1);
        check("len0_data", b1.res_data, 0);
        drive1(0, 0, 0, 0, 1);
        tick();

        // start during ACC is ignored
        drive1(1, 3, 1, 1, 0);
        tick();
        drive1(1, 9, 1, 2, 0);
        tick();
        check("ign_no_vld", 32'(b1.res_vld), 0);
        drive1(0, 0, 1, 4, 0);
        tick();
        check("ign_vld", 32'(b1.res_vld), 1);
        check("ign_data", b1.res_data, 7);
        drive1(0, 0, 0, 0, 1);
        tick();

        // stray product in IDLE
        check("pre_stray_drop", 32'(b1.drop_err), 0);
        drive1(0, 0, 1, 99, 0);
        tick();
        drive1(0, 0, 0, 0, 0);
        check("stray_drop", 32'(b1.drop_err), 1);
        tick(); tick();
        check("stray_sticky", 32'(b1.drop_err), 1);

        // saturation on the 17-bit instance, then immediate restart from HOLD
        drive2(1, 3, 1, 65535, 0); tick();
        drive2(0, 0, 1, 65535, 0); tick();
        drive2(0, 0, 1, 65535, 0); tick();
        check("sat_data", b2.res_data, 32'h1FFFF);
        check("sat_flag", 32'(b2.res_sat), 1);
        drive2(1, 1, 1, 5, 1);
        tick();
        check("sat_next_data", b2.res_data, 5);
        check("sat_next_flag", 32'(b2.res_sat), 0);
        check("sat_next_vld", 32'(b2.res_vld), 1);
        drive2(0, 0, 0, 0, 1);
        tick();
        // len=0 with a product on the start cycle drops it
        drive2(1, 0, 1, 77, 0);
        tick();
        drive2(0, 0, 0, 0, 1);
        check("len0v_data", b2.res_data, 0);
        check("len0v_drop", 32'(b2.drop_err), 1);
        tick();

        // reset mid-run
        drive1(1, 4, 1, 10, 0); tick();
        drive1(0, 0, 1, 20, 0); tick();
        drive1(0, 0, 0, 0, 0);
        check("mid_busy", 32'(b1.acc_busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(b1.acc_busy), 0);
        check("mid_rst_vld", 32'(b1.res_vld), 0);
        check("mid_rst_drop", 32'(b1.drop_err), 0);
        check("mid_rst_data", b1.res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive1(1, 1, 1, 9, 0);
        tick();
        drive1(0, 0, 0, 0, 1);
        check("post_rst_vld", 32'(b1.res_vld), 1);
        check("post_rst_data", b1.res_data, 9);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
